// File: rtl/alu_pkg.sv
// Shared types and constants for the streamed ALU responder (alu_seq_resp).
package alu_pkg;

    localparam int A_W   = 8;
    localparam int C_W   = 5;
    localparam int RES_W = 9;
    localparam int MUL_W = A_W + C_W;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_MAX = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_MUL  = 2'b10,
        ST_HOLD = 2'b11
    } state_t;

    typedef struct packed {
        logic [1:0]     sel;
        logic [C_W-1:0] c;
        logic [A_W-1:0] b;
        logic [A_W-1:0] a;
    } op_vec_t;

endpackage

// File: rtl/alu_fifo.sv
// Operand-vector FIFO: push/pop with full/empty, async active-high reset.
module alu_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 23
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/alu_seq_resp.sv
// Streamed ALU responder: queued operands, single-cycle or shift-add results, req/ack output.
// Define ALU_CNT_EN to add the res_cnt accepted-result counter.
module alu_seq_resp
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MUL_STEPS  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [A_W-1:0]   A,
    input  logic [A_W-1:0]   B,
    input  logic [C_W-1:0]   C,
    input  logic [1:0]       sel,
    output logic             full,
    output logic             ovr,
    output logic [RES_W-1:0] alu,
    output logic             req,
    input  logic             ack
`ifdef ALU_CNT_EN
    ,output logic [15:0]     res_cnt
`endif
);
    localparam int CNT_W = $clog2(MUL_STEPS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MUL_STEPS - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    op_vec_t          r_op;
    op_vec_t          w_fifo_in;
    op_vec_t          w_fifo_out;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_accept;
    logic [CNT_W-1:0] r_cnt;
    logic [MUL_W-1:0] r_acc;
    logic [MUL_W-1:0] w_addend;
    logic [MUL_W-1:0] w_acc_nxt;
    logic [RES_W-1:0] w_res;
    logic [RES_W-1:0] r_alu;
    logic             r_req;
    logic             r_ovr;

    assign w_fifo_in = '{sel: sel, c: C, b: B, a: A};

    alu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(op_vec_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (en),
        .i_pop   (w_pop),
        .i_data  (w_fifo_in),
        .o_data  (w_fifo_out),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign full = w_full;
    assign ovr  = r_ovr;
    assign alu  = r_alu;
    assign req  = r_req;

    always_comb begin
        w_res = '0;
        case (r_op.sel)
            OP_ADD:  w_res = {1'b0, r_op.a} + {1'b0, r_op.b};
            OP_SUB:  w_res = {1'b0, r_op.a} - {1'b0, r_op.b};
            OP_MAX:  w_res = {(r_op.a == r_op.b), (r_op.a >= r_op.b) ? r_op.a : r_op.b};
            default: w_res = '0;
        endcase
    end

    assign w_addend  = r_op.c[r_cnt] ? (MUL_W'(r_op.a) << r_cnt) : '0;
    assign w_acc_nxt = r_acc + w_addend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = (w_fifo_out.sel == OP_MUL) ? ST_MUL : ST_EXEC;
                end
            end
            ST_EXEC: w_state_nxt = ST_HOLD;
            ST_MUL:  if (r_cnt == LAST_STEP) w_state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (ack) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op  <= '0;
            r_cnt <= '0;
            r_acc <= '0;
            r_alu <= '0;
            r_req <= 1'b0;
            r_ovr <= 1'b0;
        end else begin
            // full is pre-pop occupancy, so a same-cycle pop never rescues the strobe
            if (en && w_full) r_ovr <= 1'b1;
            if (w_pop) begin
                r_op  <= w_fifo_out;
                r_cnt <= '0;
                r_acc <= '0;
            end
            case (r_state)
                ST_EXEC: begin
                    r_alu <= w_res;
                    r_req <= 1'b1;
                end
                ST_MUL: begin
                    r_acc <= w_acc_nxt;
                    if (r_cnt == LAST_STEP) begin
                        r_alu <= w_acc_nxt[RES_W-1:0];
                        r_req <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_HOLD: if (w_accept) r_req <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef ALU_CNT_EN
    logic [15:0] r_res_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_res_cnt <= '0;
        else if (w_accept) r_res_cnt <= r_res_cnt + 16'd1;
    end

    assign res_cnt = r_res_cnt;
`endif

endmodule
